regfile_decoded: RTL



---
 rtl/regfile_decoded.sv | 94 +++++++++
 1 files changed

// File: rtl/regfile_decoded.sv
// Register file with a one-hot write-address decoder, two combinational read ports,
// an optional hardwired zero register, optional write-to-read bypass and sticky written flags.
module regfile_decoded #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegister,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        ReadRegister1,
  input  logic [ADDR_W-1:0]        ReadRegister2,
  output logic [DATA_W-1:0]        ReadData1,
  output logic [DATA_W-1:0]        ReadData2,
  output logic [(1<<ADDR_W)-1:0]   WriteEnables,
  output logic [(1<<ADDR_W)-1:0]   Written
);

  localparam int DEPTH = 1 << ADDR_W;

  // All register contents flattened so each generate block drives only its own slice.
  logic [DEPTH*DATA_W-1:0] regFlat;
  logic [DATA_W-1:0]       stored1;
  logic [DATA_W-1:0]       stored2;

  genvar gi;

  // Decoder: one comparator per register; the zero register never gets an enable.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gDecode
      if (ZERO_EN != 0 && gi == ZERO_IDX) begin : gNoEnable
        assign WriteEnables[gi] = 1'b0;
      end else begin : gEnable
        assign WriteEnables[gi] = RegWrite && (WriteRegister == ADDR_W'(gi));
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gReg
      if (ZERO_EN != 0 && gi == ZERO_IDX) begin : gZero
        assign regFlat[gi*DATA_W +: DATA_W] = '0;
        assign Written[gi]                  = 1'b0;
      end else begin : gFlop
        logic [DATA_W-1:0] dataQ;
        logic              writtenQ;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            dataQ    <= '0;
            writtenQ <= 1'b0;
          end else if (WriteEnables[gi]) begin
            dataQ    <= WriteData;
            writtenQ <= 1'b1;
          end
        end

        assign regFlat[gi*DATA_W +: DATA_W] = dataQ;
        assign Written[gi]                  = writtenQ;
      end
    end
  endgenerate

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ReadRegister1 == ADDR_W'(i)) stored1 = regFlat[i*DATA_W +: DATA_W];
      if (ReadRegister2 == ADDR_W'(i)) stored2 = regFlat[i*DATA_W +: DATA_W];
    end
  end

  // Zero register has the last word: it overrides both storage and bypass.
  function automatic logic [DATA_W-1:0] portData(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] result;
    result = stored;
    if (BYPASS != 0 && RegWrite && addr == WriteRegister) result = WriteData;
    if (ZERO_EN != 0 && addr == ADDR_W'(ZERO_IDX)) result = '0;
    return result;
  endfunction

  always_comb begin
    ReadData1 = portData(ReadRegister1, stored1);
    ReadData2 = portData(ReadRegister2, stored2);
  end

endmodule
